// File: rtl/gen_matrix_sched.sv
// gen_matrix_sched: sequences XOF requests and the rejection-sampling parse
// datapath to build the K x K public matrix A, one polynomial at a time,
// in row-major order. Each finished polynomial is handed downstream through a
// valid/ack handshake.
// Optional feature: define GENMAT_WDOG_EN to enable the parse watchdog.
// With the watchdog, a poly whose parse does not finish within WDOG_CYCLES
// cycles of WAIT aborts the run and raises the sticky err flag.
module gen_matrix_sched #(
    parameter int K           = 3,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       transpose,
    input  logic       abort,
    output logic       xof_req,
    output logic [7:0] xof_b0,
    output logic [7:0] xof_b1,
    input  logic       xof_ack,
    output logic       parse_rst,
    output logic       parse_start,
    input  logic       parse_done,
    output logic       poly_valid,
    output logic [1:0] poly_row,
    output logic [1:0] poly_col,
    input  logic       poly_ack,
    output logic       busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [2:0] {IDLE, CLR, REQ, GO, WAIT, EMIT, NEXT, FIN} state_t;

    localparam logic [1:0] LAST = 2'(K - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] row;
    logic [1:0] col;
    logic       tp;
    logic       kill;
    logic       wdog_fire;
    logic       accept_start;
    logic       last_entry;

    assign accept_start = (state == IDLE) && start && !abort;
    assign last_entry   = (row == LAST) && (col == LAST);

`ifdef GENMAT_WDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

    logic [CNT_W-1:0] wdog_cnt;
    logic             err_q;

    assign wdog_fire = (state == WAIT) && !parse_done &&
                       (wdog_cnt == CNT_W'(WDOG_CYCLES - 1));
    assign err       = err_q;

    // Count cycles spent in WAIT; the count restarts for every poly
    always_ff @(posedge clk) begin
        if (rst || state != WAIT) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    // err stays set until reset or the next accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept_start) begin
            err_q <= 1'b0;
        end else if (wdog_fire && !abort) begin
            err_q <= 1'b1;
        end
    end
`else
    localparam int unused_wdog = WDOG_CYCLES;

    assign wdog_fire = 1'b0;
    assign err       = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Matrix position and transpose mode; advanced row-major in NEXT
    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
            tp  <= 1'b0;
        end else if (accept_start) begin
            row <= '0;
            col <= '0;
            tp  <= transpose;
        end else if (state == NEXT && !last_entry) begin
            if (col == LAST) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // One-cycle parse clear after an abort or watchdog exit, shown while in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            kill <= 1'b0;
        end else begin
            kill <= (abort && state != IDLE) || wdog_fire;
        end
    end

    // Next-state logic and Moore outputs
    always_comb begin
        state_nxt   = state;
        xof_req     = 1'b0;
        parse_rst   = kill;
        parse_start = 1'b0;
        poly_valid  = 1'b0;
        done        = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: if (accept_start) state_nxt = CLR;
            CLR: begin
                parse_rst = 1'b1;
                state_nxt = REQ;
            end
            REQ: begin
                xof_req = 1'b1;
                if (xof_ack) state_nxt = GO;
            end
            GO: begin
                parse_start = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (parse_done) begin
                    state_nxt = EMIT;
                end else if (wdog_fire) begin
                    state_nxt = IDLE;
                end
            end
            EMIT: begin
                poly_valid = 1'b1;
                if (poly_ack) state_nxt = NEXT;
            end
            NEXT: state_nxt = last_entry ? FIN : CLR;
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
        end
    end

    assign xof_b0   = tp ? {6'b0, row} : {6'b0, col};
    assign xof_b1   = tp ? {6'b0, col} : {6'b0, row};
    assign poly_row = row;
    assign poly_col = col;

endmodule

// File: tb/tb_gen_matrix_sched.sv
// Scoreboard bench for gen_matrix_sched: behavioural XOF, parse and consumer
// models with randomized latencies; expected XOF indices, poly order and done
// pulses are queued from the matrix-generation rules and popped by a monitor.
module tb_gen_matrix_sched;
    logic       clk = 1'b0;
    logic       rst, start, transpose, abort;
    logic       xof_req, xof_ack, parse_rst, parse_start, parse_done;
    logic       poly_valid, poly_ack, busy, done, err;
    logic [7:0] xof_b0, xof_b1;
    logic [1:0] poly_row, poly_col;

    always #5 clk = ~clk;

    gen_matrix_sched #(.K(3), .WDOG_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .transpose(transpose), .abort(abort),
        .xof_req(xof_req), .xof_b0(xof_b0), .xof_b1(xof_b1), .xof_ack(xof_ack),
        .parse_rst(parse_rst), .parse_start(parse_start), .parse_done(parse_done),
        .poly_valid(poly_valid), .poly_row(poly_row), .poly_col(poly_col),
        .poly_ack(poly_ack), .busy(busy), .done(done), .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_xof[$];
    logic [3:0]  exp_poly[$];
    int exp_done  = 0;
    int done_seen = 0;
    int xof_dly = 0, poly_dly = 0, parse_lo = 1, parse_hi = 6;
    bit rnd_dly = 0, withhold = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not expected or not reached", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // XOF front end: acks each request after a fixed or random delay
    initial begin : xof_model
        int w;
        int tgt;
        bit pend;
        pend = 0; w = 0; tgt = 0;
        xof_ack = 1'b0;
        forever begin
            tick();
            xof_ack = 1'b0;
            if (xof_req) begin
                if (!pend) begin
                    pend = 1; w = 0;
                    tgt = rnd_dly ? int'($urandom_range(0, 4)) : xof_dly;
                end
                if (w >= tgt) begin
                    xof_ack = 1'b1; pend = 0;
                end else w++;
            end else pend = 0;
        end
    end

    // Consumer: captures each offered poly after a fixed or random delay
    initial begin : consumer_model
        int w;
        int tgt;
        bit pend;
        pend = 0; w = 0; tgt = 0;
        poly_ack = 1'b0;
        forever begin
            tick();
            poly_ack = 1'b0;
            if (poly_valid) begin
                if (!pend) begin
                    pend = 1; w = 0;
                    tgt = rnd_dly ? int'($urandom_range(0, 4)) : poly_dly;
                end
                if (w >= tgt) begin
                    poly_ack = 1'b1; pend = 0;
                end else w++;
            end else pend = 0;
        end
    end

    // Parse datapath: level-high done some cycles after start, cleared by parse_rst
    initial begin : parse_model
        int cnt;
        cnt = 0;
        parse_done = 1'b0;
        forever begin
            tick();
            if (parse_rst) begin
                parse_done = 1'b0; cnt = 0;
            end else if (parse_start) begin
                cnt = $urandom_range(parse_lo, parse_hi);
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && !withhold) parse_done = 1'b1;
            end
        end
    end

    // Monitor: pops expectations on every accepted handshake and done pulse
    initial begin : monitor
        logic [15:0] px;
        logic [3:0]  pp;
        bit pend_x, pend_p;
        int starts;
        pend_x = 0; pend_p = 0; starts = 0; px = '0; pp = '0;
        forever begin
            @(negedge clk);
            if (!busy) starts = 0;
            if (parse_start) starts++;
            if (xof_req) begin
                if (pend_x) check("xof_idx_stable", {xof_b0, xof_b1}, px);
                if (xof_ack) begin
                    if (exp_xof.size() == 0) fail("xof_unexpected_req");
                    else check("xof_idx", {xof_b0, xof_b1}, exp_xof.pop_front());
                    pend_x = 0;
                end else begin
                    pend_x = 1; px = {xof_b0, xof_b1};
                end
            end else pend_x = 0;
            if (poly_valid) begin
                if (pend_p) check("poly_idx_stable", {poly_row, poly_col}, pp);
                if (poly_ack) begin
                    if (exp_poly.size() == 0) fail("poly_unexpected");
                    else check("poly_order", {poly_row, poly_col}, exp_poly.pop_front());
                    check("parse_starts_per_poly", starts, 1);
                    starts = 0;
                    pend_p = 0;
                end else begin
                    pend_p = 1; pp = {poly_row, poly_col};
                end
            end else pend_p = 0;
            if (done) begin
                done_seen++;
                if (exp_done == 0) fail("done_unexpected");
                else begin
                    exp_done--;
                    check("done_after_last_poly", exp_poly.size(), 0);
                end
            end
        end
    end

    task automatic push_matrix(input bit tp);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                exp_poly.push_back({2'(r), 2'(c)});
                exp_xof.push_back(tp ? {8'(r), 8'(c)} : {8'(c), 8'(r)});
            end
        end
        exp_done++;
    endtask

    task automatic pulse_start(input bit tp);
        transpose = tp;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_matrix(input bit tp, input bit noise);
        int d0;
        d0 = done_seen;
        push_matrix(tp);
        pulse_start(tp);
        for (int i = 0; i < 3000 && done_seen == d0; i++) begin
            start = noise && busy && ($urandom_range(0, 5) == 0);
            tick();
        end
        start = 1'b0;
        check("run_done_count", done_seen - d0, 1);
        check("poly_queue_drained", exp_poly.size(), 0);
        check("xof_queue_drained", exp_xof.size(), 0);
        tick();
        tick();
        check("idle_after_run", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_xof_req"}, xof_req, 0);
        check({tag, "_xof_b"}, {xof_b0, xof_b1}, 0);
        check({tag, "_parse_rst"}, parse_rst, 0);
        check({tag, "_parse_start"}, parse_start, 0);
        check({tag, "_poly_valid"}, poly_valid, 0);
        check({tag, "_poly_idx"}, {poly_row, poly_col}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic flush();
        exp_xof.delete();
        exp_poly.delete();
        exp_done = 0;
    endtask

    initial begin : global_timeout
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        bit found;
        int d0;
        rst = 1'b1; start = 1'b0; transpose = 1'b0; abort = 1'b0;
        tick(); tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Immediate acks, normal then transposed order
        run_matrix(0, 0);
        run_matrix(1, 0);

        // Slow XOF and slow consumer
        xof_dly = 10; poly_dly = 5;
        run_matrix(0, 0);
        xof_dly = 0; poly_dly = 0;

        // Random latencies, random transpose, start pulses while busy
        rnd_dly = 1;
        for (int k = 0; k < 3; k++) run_matrix(1'($urandom_range(0, 1)), 1);
        rnd_dly = 0;

        // Abort during WAIT of poly (1,1)
        parse_lo = 30; parse_hi = 30;
        d0 = done_seen;
        push_matrix(0);
        pulse_start(0);
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            #1;
            found = (exp_xof.size() == 4) && parse_start;
        end
        if (!found) fail("abort_wait_timeout");
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_parse_rst", parse_rst, 1);
        check("abort_xof_req", xof_req, 0);
        check("abort_poly_valid", poly_valid, 0);
        check("abort_polys_left", exp_poly.size(), 5);
        flush();
        for (int i = 0; i < 5; i++) tick();
        check("abort_no_done", done_seen - d0, 0);
        check("abort_stays_idle", busy, 0);
        parse_lo = 1; parse_hi = 6;
        run_matrix(0, 0);

        // start together with abort while idle
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_parse_rst", parse_rst, 0);
        tick(); tick();
        check("start_abort_no_req", xof_req, 0);

        // Reset while offering poly (0,2)
        poly_dly = 20;
        push_matrix(0);
        pulse_start(0);
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            #1;
            found = poly_valid && (exp_poly.size() == 7);
        end
        if (!found) fail("emit_wait_timeout");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("mid_emit_rst");
        flush();
        poly_dly = 0;
        tick();
        rnd_dly = 1;
        run_matrix(1, 0);
        rnd_dly = 0;

`ifdef GENMAT_WDOG_EN
        // Parse never completes: watchdog fires after 16 WAIT cycles
        withhold = 1;
        d0 = done_seen;
        exp_xof.push_back(16'h0000);
        pulse_start(0);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            #1;
            found = parse_start;
        end
        if (!found) fail("wdog_start_timeout");
        for (int i = 0; i < 16; i++) tick();
        check("wdog_err_before", err, 0);
        check("wdog_busy_before", busy, 1);
        tick();
        check("wdog_err", err, 1);
        check("wdog_busy", busy, 0);
        check("wdog_parse_rst", parse_rst, 1);
        for (int i = 0; i < 4; i++) tick();
        check("wdog_no_done", done_seen - d0, 0);
        check("wdog_err_sticky", err, 1);
        withhold = 0;
        run_matrix(0, 0);
        check("wdog_err_cleared", err, 0);
`else
        check("err_tied_low", err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
